// File: rtl/cam_ap_array_pkg.sv
// Shared types for the associative-processor CAM array: op codes, tag
// combine modes, FSM states and the clog2 helper used to size row indices.
package cam_ap_pkg;

  typedef enum logic [2:0] {
    OP_WRITE        = 3'd0,
    OP_READ         = 3'd1,
    OP_COMPARE      = 3'd2,
    OP_WRITE_TAGGED = 3'd3,
    OP_TAG_CLEAR    = 3'd4,
    OP_TAG_NEXT     = 3'd5,
    OP_TAG_SET_ALL  = 3'd6,
    OP_RESERVED     = 3'd7
  } cam_op_e;

  typedef enum logic [1:0] {
    MODE_SET    = 2'd0,
    MODE_AND    = 2'd1,
    MODE_OR     = 2'd2,
    MODE_ANDNOT = 2'd3
  } tag_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_STAT = 2'd2
  } cam_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cam_ap_array_if.sv
// Command/response port of the CAM array; the requester uses master, the
// array uses slave.
interface cam_ap_if #(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_BITS = 7
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic [WORD_SIZE-1:0] cmd_data;
  logic [WORD_SIZE-1:0] cmd_key;
  logic [WORD_SIZE-1:0] cmd_mask;
  logic [1:0]           cmd_tag_mode;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_data;
  logic [ADDR_BITS-1:0] rsp_addr;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask, cmd_tag_mode,
    input  cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_key, cmd_mask, cmd_tag_mode,
    output cmd_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/cam_ap_array_tag_stat.sv
// Combinational tag summary: any-set flag, lowest set index and popcount.
// The parent registers these outputs once the tag register has settled.
module cam_tag_stat #(
  parameter int CELL_QUANT = 128,
  parameter int ADDR_BITS  = 7
) (
  input  logic [CELL_QUANT-1:0] tags,
  output logic                  any_set,
  output logic [ADDR_BITS-1:0]  first_idx,
  output logic [ADDR_BITS:0]    count
);

  always_comb begin
    any_set   = |tags;
    first_idx = '0;
    count     = '0;
    // Descending scan so the lowest set index is the last one written.
    for (int i = CELL_QUANT - 1; i >= 0; i--) begin
      if (tags[i]) first_idx = ADDR_BITS'(i);
    end
    for (int i = 0; i < CELL_QUANT; i++) begin
      count = count + {{ADDR_BITS{1'b0}}, tags[i]};
    end
  end

endmodule

// File: rtl/cam_ap_array.sv
// Associative-processor CAM array: addressed read/write, masked parallel compare
// into tags, tagged masked write and tag iteration. CAM_DUAL_KEY_EN adds a second key/mask for odd rows.
module cam_ap_array
  import cam_ap_pkg::*;
#(
  parameter int   WORD_SIZE  = 8,
  parameter int   CELL_QUANT = 128,
  localparam int  ADDR_BITS  = clog2(CELL_QUANT)
) (
  input  logic                  clock,
  input  logic                  rst,
  cam_ap_if.slave               bus,
`ifdef CAM_DUAL_KEY_EN
  input  logic                  direction,
  input  logic [WORD_SIZE-1:0]  key_h,
  input  logic [WORD_SIZE-1:0]  mask_h,
`endif
  output logic [CELL_QUANT-1:0] tags,
  output logic                  tag_any,
  output logic [ADDR_BITS-1:0]  tag_first,
  output logic [ADDR_BITS:0]    tag_count
);

  cam_state_e           state_reg;
  cam_op_e              op_reg;
  tag_mode_e            mode_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [WORD_SIZE-1:0] data_reg, key_reg, mask_reg;
`ifdef CAM_DUAL_KEY_EN
  logic                 dir_reg;
  logic [WORD_SIZE-1:0] key_h_reg, mask_h_reg;
`endif

  // Rows live in flops: every row is read in parallel by compare.
  logic [WORD_SIZE-1:0] mem_reg [CELL_QUANT];
  logic [WORD_SIZE-1:0] wt_row  [CELL_QUANT];
  logic [CELL_QUANT-1:0] tags_reg, match;

  logic                 tag_any_reg, stat_any;
  logic [ADDR_BITS-1:0] tag_first_reg, stat_first;
  logic [ADDR_BITS:0]   tag_count_reg, stat_count;

  logic                 rsp_valid_reg, rsp_err_reg;
  logic [WORD_SIZE-1:0] rsp_data_reg;
  logic [ADDR_BITS-1:0] rsp_addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CELL_QUANT; gi++) begin : g_row
      logic [WORD_SIZE-1:0] key_sel, mask_sel;
`ifdef CAM_DUAL_KEY_EN
      if (gi % 2 == 1) begin : g_odd
        assign key_sel  = dir_reg ? key_h_reg  : key_reg;
        assign mask_sel = dir_reg ? mask_h_reg : mask_reg;
      end else begin : g_even
        assign key_sel  = key_reg;
        assign mask_sel = mask_reg;
      end
`else
      assign key_sel  = key_reg;
      assign mask_sel = mask_reg;
`endif
      assign match[gi]  = ((mem_reg[gi] ^ key_sel) & mask_sel) == '0;
      assign wt_row[gi] = (mem_reg[gi] & ~mask_sel) | (data_reg & mask_sel);
    end
  endgenerate

  cam_tag_stat #(
    .CELL_QUANT (CELL_QUANT),
    .ADDR_BITS  (ADDR_BITS)
  ) u_tag_stat (
    .tags      (tags_reg),
    .any_set   (stat_any),
    .first_idx (stat_first),
    .count     (stat_count)
  );

  always_ff @(posedge clock) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_WRITE;
      mode_reg      <= MODE_SET;
      addr_reg      <= '0;
      data_reg      <= '0;
      key_reg       <= '0;
      mask_reg      <= '0;
`ifdef CAM_DUAL_KEY_EN
      dir_reg       <= 1'b0;
      key_h_reg     <= '0;
      mask_h_reg    <= '0;
`endif
      tags_reg      <= '0;
      tag_any_reg   <= 1'b0;
      tag_first_reg <= '0;
      tag_count_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_addr_reg  <= '0;
      for (int i = 0; i < CELL_QUANT; i++) mem_reg[i] <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            op_reg    <= cam_op_e'(bus.cmd_op);
            mode_reg  <= tag_mode_e'(bus.cmd_tag_mode);
            addr_reg  <= bus.cmd_addr;
            data_reg  <= bus.cmd_data;
            key_reg   <= bus.cmd_key;
            mask_reg  <= bus.cmd_mask;
`ifdef CAM_DUAL_KEY_EN
            dir_reg    <= direction;
            key_h_reg  <= key_h;
            mask_h_reg <= mask_h;
`endif
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          case (op_reg)
            OP_WRITE: mem_reg[addr_reg] <= data_reg;
            OP_READ: begin
              rsp_data_reg <= mem_reg[addr_reg];
              rsp_addr_reg <= addr_reg;
            end
            OP_WRITE_TAGGED: begin
              for (int i = 0; i < CELL_QUANT; i++) begin
                if (tags_reg[i]) mem_reg[i] <= wt_row[i];
              end
            end
            OP_COMPARE, OP_TAG_CLEAR, OP_TAG_NEXT, OP_TAG_SET_ALL: begin
              // Tag ops respond from STAT, after the status registers refresh.
              state_reg     <= ST_STAT;
              rsp_valid_reg <= 1'b0;
              if (op_reg == OP_COMPARE) begin
                case (mode_reg)
                  MODE_SET: tags_reg <= match;
                  MODE_AND: tags_reg <= tags_reg & match;
                  MODE_OR:  tags_reg <= tags_reg | match;
                  default:  tags_reg <= tags_reg & ~match;
                endcase
              end else if (op_reg == OP_TAG_CLEAR) begin
                tags_reg <= '0;
              end else if (op_reg == OP_TAG_SET_ALL) begin
                tags_reg <= '1;
              end else if (tag_any_reg) begin
                tags_reg[tag_first_reg] <= 1'b0;
              end
            end
            default: rsp_err_reg <= 1'b1;
          endcase
        end
        ST_STAT: begin
          state_reg     <= ST_IDLE;
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= 1'b0;
          tag_any_reg   <= stat_any;
          tag_first_reg <= stat_first;
          tag_count_reg <= stat_count;
          // tag_first_reg still names the row TAG_NEXT just consumed.
          if (op_reg == OP_TAG_NEXT) begin
            if (tag_any_reg) begin
              rsp_addr_reg <= tag_first_reg;
              rsp_data_reg <= mem_reg[tag_first_reg];
            end else begin
              rsp_err_reg  <= 1'b1;
              rsp_addr_reg <= '0;
              rsp_data_reg <= '0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_reg == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_addr  = rsp_addr_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign tags          = tags_reg;
  assign tag_any       = tag_any_reg;
  assign tag_first     = tag_first_reg;
  assign tag_count     = tag_count_reg;

endmodule

// File: tb/tb_cam_ap_array.sv
// Directed bench for cam_ap_array with 16 rows: each task drives one scenario
// and checks hand-computed results inline.
module tb_cam_ap_array;
  import cam_ap_pkg::*;

  localparam int WS = 8;
  localparam int CQ = 16;
  localparam int AB = 4;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  cam_ap_if #(.WORD_SIZE(WS), .ADDR_BITS(AB)) bus ();

  logic [CQ-1:0] tags;
  logic          tag_any;
  logic [AB-1:0] tag_first;
  logic [AB:0]   tag_count;
`ifdef CAM_DUAL_KEY_EN
  logic          direction = 1'b0;
  logic [WS-1:0] key_h     = '0;
  logic [WS-1:0] mask_h    = '0;
`endif

  cam_ap_array #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .clock     (clock),
    .rst       (rst),
    .bus       (bus),
`ifdef CAM_DUAL_KEY_EN
    .direction (direction),
    .key_h     (key_h),
    .mask_h    (mask_h),
`endif
    .tags      (tags),
    .tag_any   (tag_any),
    .tag_first (tag_first),
    .tag_count (tag_count)
  );

  int total = 0;
  int bad   = 0;
  int lat;

  // Drive one command, hold it until accepted and count edges (accept edge = 1)
  // up to the response pulse; -1 means no response within the budget.
  task automatic issue(input logic [2:0] op, input logic [AB-1:0] addr,
                       input logic [WS-1:0] data, input logic [WS-1:0] key,
                       input logic [WS-1:0] mask, input logic [1:0] mode,
                       output int l);
    int n;
    @(negedge clock);
    bus.cmd_valid = 1'b1;  bus.cmd_op = op;     bus.cmd_addr = addr;
    bus.cmd_data  = data;  bus.cmd_key = key;   bus.cmd_mask = mask;
    bus.cmd_tag_mode = mode;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    l = 1;
    while (!bus.rsp_valid && l < 20) begin
      @(posedge clock);
      #1;
      l++;
    end
    if (!bus.rsp_valid) l = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (bus.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (bus.rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp_data: got %h want 00", bus.rsp_data); end
    total++; if (tags !== 16'h0000) begin bad++; $display("FAIL reset_tags: got %h want 0000", tags); end
    total++; if (tag_count !== 5'd0 || tag_any !== 1'b0) begin bad++; $display("FAIL reset_status: count %0d any %b want 0 0", tag_count, tag_any); end
    @(negedge clock);
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    logic [WS-1:0] wv [4];
    wv = '{8'h10, 8'h21, 8'h10, 8'h33};
    for (int i = 0; i < 4; i++) begin
      issue(OP_WRITE, AB'(i), wv[i], 8'h00, 8'h00, 2'd0, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL write_latency row %0d: got %0d want 2", i, lat); end
    end
    issue(OP_READ, 4'd2, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL read_latency: got %0d want 2", lat); end
    total++; if (bus.rsp_data !== 8'h10 || bus.rsp_addr !== 4'd2) begin bad++; $display("FAIL read_row2: got %h@%0d want 10@2", bus.rsp_data, bus.rsp_addr); end
    total++; if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL read_err: got %b want 0", bus.rsp_err); end
    issue(OP_READ, 4'd9, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h00 || bus.rsp_addr !== 4'd9) begin bad++; $display("FAIL read_row9: got %h@%0d want 00@9", bus.rsp_data, bus.rsp_addr); end
  endtask

  task automatic test_compare();
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h10, 8'hFF, MODE_SET, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL compare_latency: got %0d want 3", lat); end
    total++; if (tags !== 16'h0005 || tag_count !== 5'd2 || tag_first !== 4'd0 || tag_any !== 1'b1) begin bad++;
      $display("FAIL compare_set: tags %h count %0d first %0d any %b want 0005 2 0 1", tags, tag_count, tag_first, tag_any); end
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h01, 8'h0F, MODE_AND, lat);
    total++; if (tags !== 16'h0000 || tag_any !== 1'b0 || tag_count !== 5'd0) begin bad++;
      $display("FAIL compare_and: tags %h any %b count %0d want 0000 0 0", tags, tag_any, tag_count); end
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h33, 8'hFF, MODE_OR, lat);
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h21, 8'hFF, MODE_OR, lat);
    total++; if (tags !== 16'h000A || tag_first !== 4'd1 || tag_count !== 5'd2) begin bad++;
      $display("FAIL compare_or: tags %h first %0d count %0d want 000a 1 2", tags, tag_first, tag_count); end
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h01, 8'h0F, MODE_ANDNOT, lat);
    total++; if (tags !== 16'h0008 || tag_first !== 4'd3 || tag_count !== 5'd1) begin bad++;
      $display("FAIL compare_andnot: tags %h first %0d count %0d want 0008 3 1", tags, tag_first, tag_count); end
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h5A, 8'h00, MODE_SET, lat);
    total++; if (tags !== 16'hFFFF || tag_count !== 5'd16 || tag_first !== 4'd0) begin bad++;
      $display("FAIL compare_mask0: tags %h count %0d first %0d want ffff 16 0", tags, tag_count, tag_first); end
  endtask

  task automatic test_write_tagged();
    issue(OP_TAG_CLEAR, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (tags !== 16'h0000 || tag_count !== 5'd0 || lat !== 3) begin bad++;
      $display("FAIL tag_clear: tags %h count %0d lat %0d want 0000 0 3", tags, tag_count, lat); end
    issue(OP_WRITE_TAGGED, 4'd0, 8'h0A, 8'h00, 8'h0F, 2'd0, lat);
    total++; if (lat !== 2 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL wt_empty: lat %0d err %b want 2 0", lat, bus.rsp_err); end
    issue(OP_READ, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h10) begin bad++; $display("FAIL wt_empty_row0: got %h want 10", bus.rsp_data); end
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h10, 8'hF0, MODE_SET, lat);
    total++; if (tags !== 16'h0005) begin bad++; $display("FAIL compare_hinib: tags %h want 0005", tags); end
    issue(OP_WRITE_TAGGED, 4'd0, 8'h0A, 8'h00, 8'h0F, 2'd0, lat);
    issue(OP_READ, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h1A) begin bad++; $display("FAIL wt_row0: got %h want 1a", bus.rsp_data); end
    issue(OP_READ, 4'd1, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h21) begin bad++; $display("FAIL wt_row1: got %h want 21", bus.rsp_data); end
    issue(OP_READ, 4'd2, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h1A) begin bad++; $display("FAIL wt_row2: got %h want 1a", bus.rsp_data); end
  endtask

  task automatic test_tag_next();
    issue(OP_TAG_NEXT, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (lat !== 3 || bus.rsp_addr !== 4'd0 || bus.rsp_data !== 8'h1A || bus.rsp_err !== 1'b0) begin bad++;
      $display("FAIL tag_next1: lat %0d addr %0d data %h err %b want 3 0 1a 0", lat, bus.rsp_addr, bus.rsp_data, bus.rsp_err); end
    total++; if (tag_count !== 5'd1 || tags !== 16'h0004 || tag_first !== 4'd2) begin bad++;
      $display("FAIL tag_next1_status: tags %h count %0d first %0d want 0004 1 2", tags, tag_count, tag_first); end
    issue(OP_TAG_NEXT, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_addr !== 4'd2 || bus.rsp_data !== 8'h1A || tag_count !== 5'd0 || tag_any !== 1'b0) begin bad++;
      $display("FAIL tag_next2: addr %0d data %h count %0d any %b want 2 1a 0 0", bus.rsp_addr, bus.rsp_data, tag_count, tag_any); end
    issue(OP_TAG_NEXT, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 8'h00 || bus.rsp_addr !== 4'd0 || tags !== 16'h0000) begin bad++;
      $display("FAIL tag_next_empty: err %b data %h addr %0d tags %h want 1 00 0 0000", bus.rsp_err, bus.rsp_data, bus.rsp_addr, tags); end
  endtask

  task automatic test_set_all_reserved();
    issue(OP_TAG_SET_ALL, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (tags !== 16'hFFFF || tag_count !== 5'd16 || tag_first !== 4'd0) begin bad++;
      $display("FAIL set_all: tags %h count %0d first %0d want ffff 16 0", tags, tag_count, tag_first); end
    issue(3'd7, 4'd5, 8'hEE, 8'h00, 8'h00, 2'd0, lat);
    total++; if (lat !== 2 || bus.rsp_err !== 1'b1 || tags !== 16'hFFFF || tag_count !== 5'd16) begin bad++;
      $display("FAIL reserved: lat %0d err %b tags %h count %0d want 2 1 ffff 16", lat, bus.rsp_err, tags, tag_count); end
    issue(OP_TAG_NEXT, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_addr !== 4'd0 || bus.rsp_data !== 8'h1A || tag_count !== 5'd15 || tag_first !== 4'd1) begin bad++;
      $display("FAIL next_after_all: addr %0d data %h count %0d first %0d want 0 1a 15 1", bus.rsp_addr, bus.rsp_data, tag_count, tag_first); end
    issue(OP_READ, 4'd5, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    total++; if (bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reserved_no_write: data %h err %b want 00 0", bus.rsp_data, bus.rsp_err); end
  endtask

  task automatic test_back_to_back();
    int   pulses;
    logic prev, adjacent, ready_busy;
    pulses = 0; prev = 1'b0; adjacent = 1'b0; ready_busy = 1'b1;
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_READ; bus.cmd_addr = 4'd3;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (i == 0) ready_busy = bus.cmd_ready;
      if (bus.rsp_valid) begin
        pulses++;
        if (prev) adjacent = 1'b1;
      end
      prev = bus.rsp_valid;
    end
    bus.cmd_valid = 1'b0;
    total++; if (ready_busy !== 1'b0) begin bad++; $display("FAIL b2b_ready_busy: got %b want 0", ready_busy); end
    total++; if (pulses !== 3 || adjacent !== 1'b0) begin bad++; $display("FAIL b2b_pulses: got %0d adjacent %b want 3 0", pulses, adjacent); end
    total++; if (bus.rsp_data !== 8'h33 || bus.rsp_addr !== 4'd3) begin bad++; $display("FAIL b2b_data: got %h@%0d want 33@3", bus.rsp_data, bus.rsp_addr); end
  endtask

  task automatic test_reset_abort();
    issue(OP_TAG_SET_ALL, 4'd0, 8'h00, 8'h00, 8'h00, 2'd0, lat);
    @(negedge clock);
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_WRITE_TAGGED; bus.cmd_data = 8'hFF; bus.cmd_mask = 8'hFF;
    @(posedge clock);
    #1;
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(posedge clock);
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL abort_rsp_valid: got %b want 0", bus.rsp_valid); end
    total++; if (tags !== 16'h0000 || tag_count !== 5'd0 || tag_any !== 1'b0) begin bad++;
      $display("FAIL abort_tags: tags %h count %0d any %b want 0000 0 0", tags, tag_count, tag_any); end
    @(negedge clock);
    rst = 1'b1;
    @(posedge clock);
    #1;
    total++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++;
      $display("FAIL abort_ready: ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid); end
    for (int i = 0; i < 4; i++) begin
      issue(OP_READ, AB'(i), 8'h00, 8'h00, 8'h00, 2'd0, lat);
      total++; if (bus.rsp_data !== 8'h00 || lat !== 2) begin bad++; $display("FAIL abort_row %0d: data %h lat %0d want 00 2", i, bus.rsp_data, lat); end
    end
  endtask

`ifdef CAM_DUAL_KEY_EN
  task automatic test_dual_key();
    logic [WS-1:0] wv [4];
    wv = '{8'h10, 8'h21, 8'h10, 8'h33};
    for (int i = 0; i < 4; i++) issue(OP_WRITE, AB'(i), wv[i], 8'h00, 8'h00, 2'd0, lat);
    direction = 1'b1; key_h = 8'h21; mask_h = 8'hFF;
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h10, 8'hFF, MODE_SET, lat);
    total++; if (tags !== 16'h0007 || tag_count !== 5'd3) begin bad++; $display("FAIL dual_key_on: tags %h count %0d want 0007 3", tags, tag_count); end
    direction = 1'b0;
    issue(OP_COMPARE, 4'd0, 8'h00, 8'h10, 8'hFF, MODE_SET, lat);
    total++; if (tags !== 16'h0005 || tag_count !== 5'd2) begin bad++; $display("FAIL dual_key_off: tags %h count %0d want 0005 2", tags, tag_count); end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.cmd_key = '0; bus.cmd_mask = '0; bus.cmd_tag_mode = 2'd0;
    test_reset();
    test_write_read();
    test_compare();
    test_write_tagged();
    test_tag_next();
    test_set_all_reserved();
    test_back_to_back();
    test_reset_abort();
`ifdef CAM_DUAL_KEY_EN
    test_dual_key();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
